// File: rtl/regwb_pkg.sv
// Shared constants and types for the register write-back arbiter.
package regwb_pkg;

    localparam int unsigned DEF_NREQ = 3;
    localparam int unsigned DEF_AW   = 6;
    localparam int unsigned DEF_DW   = 32;

    typedef logic [DEF_AW-1:0] reg_addr_t;
    typedef logic [DEF_DW-1:0] reg_data_t;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regwb_arbiter_rr_arbiter.sv
// Round-robin grant logic: the search starts at ptr, ascends modulo N,
// and ptr moves just past the winner. Grants are forced low during reset.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr) + off) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_nxt    = (32'(idx) == N - 1) ? '0 : idx + PW'(1);
            end
        end
        if (!rstn) begin
            grant   = '0;
            ptr_nxt = ptr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write-back arbiter with registered write port and busy scoreboard.
// Optional feature: define REGWB_ZERO_DISCARD_EN to drop writes to register 0.
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    output logic [(2**AW)-1:0] busy_vec
);

    logic [NREQ-1:0]    grant;
    logic               any_grant;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic               we_nxt;
    logic [(2**AW)-1:0] busy_nxt;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        any_grant = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                any_grant = 1'b1;
                sel_addr  = req_addr[i*AW +: AW];
                sel_data  = req_data[i*DW +: DW];
            end
        end
`ifdef REGWB_ZERO_DISCARD_EN
        // The handshake still completes; only the register-file write is suppressed.
        we_nxt = any_grant && (sel_addr != AW'(ZERO_REG));
`else
        we_nxt = any_grant;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= we_nxt;
            if (we_nxt) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // Clear before set so a same-cycle re-reservation keeps the register busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (rf_we) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed vector bench for regwb_arbiter: per-cycle table plus reset and round-robin sequences.
module tb_regwb_arbiter;
    import regwb_pkg::*;

    logic         clk;
    logic         rstn;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [17:0]  req_addr;
    logic [95:0]  req_data;
    logic         rf_we;
    logic [5:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         rsv_valid;
    logic [5:0]   rsv_addr;
    logic [63:0]  busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    reg_data_t rfm [64];

`ifdef REGWB_ZERO_DISCARD_EN
    localparam logic        Z_WE = 1'b0;
    localparam logic [5:0]  Z_A  = 6'd12;
    localparam logic [31:0] Z_D  = 32'd3;
`else
    localparam logic        Z_WE = 1'b1;
    localparam logic [5:0]  Z_A  = 6'd0;
    localparam logic [31:0] Z_D  = 32'd10;
`endif

    localparam logic [63:0] B5 = 64'h20;
    localparam logic [63:0] B9 = 64'h200;

    regwb_arbiter #(.NREQ(3), .AW(6), .DW(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rfm[rf_waddr] <= rf_wdata;
    end

    typedef struct {
        logic [2:0]  valid;
        logic [17:0] addr;
        logic [95:0] data;
        logic        rv;
        logic [5:0]  ra;
        logic [2:0]  erdy;
        logic        ewe;
        logic [5:0]  ewa;
        logic [31:0] ewd;
        logic [63:0] ebusy;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic rv, input logic [5:0] ra,
                                input logic [2:0] erdy, input logic ewe, input logic [5:0] ewa,
                                input logic [31:0] ewd, input logic [63:0] ebusy);
        vec_t r;
        r.valid = v;
        r.addr  = {a2, a1, a0};
        r.data  = {d2, d1, d0};
        r.rv    = rv;
        r.ra    = ra;
        r.erdy  = erdy;
        r.ewe   = ewe;
        r.ewa   = ewa;
        r.ewd   = ewd;
        r.ebusy = ebusy;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vt [24];
    logic [31:0] rrd [3];

    initial begin
        // Check values describe the state seen in that cycle (outputs registered from the previous one).
        vt[0]  = mk(3'b001, 6'd1, 6'd0, 6'd0, 32'd32, 32'd0, 32'd0, 1'b0, 6'd0, 3'b001, 1'b0, 6'd0, 32'd0, 64'd0);
        vt[1]  = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b1, 6'd1, 32'd32, 64'd0);
        vt[2]  = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b0, 6'd1, 32'd32, 64'd0);
        vt[3]  = mk(3'b111, 6'd2, 6'd3, 6'd4, 32'd100, 32'd101, 32'd102, 1'b0, 6'd0, 3'b010, 1'b0, 6'd1, 32'd32, 64'd0);
        vt[4]  = mk(3'b111, 6'd2, 6'd3, 6'd4, 32'd100, 32'd101, 32'd102, 1'b0, 6'd0, 3'b100, 1'b1, 6'd3, 32'd101, 64'd0);
        vt[5]  = mk(3'b111, 6'd2, 6'd3, 6'd4, 32'd100, 32'd101, 32'd102, 1'b0, 6'd0, 3'b001, 1'b1, 6'd4, 32'd102, 64'd0);
        vt[6]  = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b1, 6'd2, 32'd100, 64'd0);
        vt[7]  = mk(3'b110, 6'd0, 6'd5, 6'd5, 32'd0, 32'd21, 32'd200, 1'b0, 6'd0, 3'b010, 1'b0, 6'd2, 32'd100, 64'd0);
        vt[8]  = mk(3'b100, 6'd0, 6'd5, 6'd5, 32'd0, 32'd21, 32'd200, 1'b0, 6'd0, 3'b100, 1'b1, 6'd5, 32'd21, 64'd0);
        vt[9]  = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b1, 6'd5, 32'd200, 64'd0);
        vt[10] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1, 6'd5, 3'b000, 1'b0, 6'd5, 32'd200, 64'd0);
        vt[11] = mk(3'b001, 6'd5, 6'd0, 6'd0, 32'd7, 32'd0, 32'd0, 1'b0, 6'd0, 3'b001, 1'b0, 6'd5, 32'd200, B5);
        vt[12] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1, 6'd5, 3'b000, 1'b1, 6'd5, 32'd7, B5);
        vt[13] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1, 6'd0, 3'b000, 1'b0, 6'd5, 32'd7, B5);
        vt[14] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1, 6'd9, 3'b000, 1'b0, 6'd5, 32'd7, B5);
        vt[15] = mk(3'b010, 6'd0, 6'd9, 6'd0, 32'd0, 32'd55, 32'd0, 1'b0, 6'd0, 3'b010, 1'b0, 6'd5, 32'd7, B5 | B9);
        vt[16] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b1, 6'd9, 32'd55, B5 | B9);
        vt[17] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b0, 6'd9, 32'd55, B5);
        vt[18] = mk(3'b100, 6'd0, 6'd0, 6'd12, 32'd0, 32'd0, 32'd3, 1'b0, 6'd0, 3'b100, 1'b0, 6'd9, 32'd55, B5);
        vt[19] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b1, 6'd12, 32'd3, B5);
        vt[20] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, 1'b0, 6'd12, 32'd3, B5);
        vt[21] = mk(3'b001, 6'd0, 6'd0, 6'd0, 32'd10, 32'd0, 32'd0, 1'b0, 6'd0, 3'b001, 1'b0, 6'd12, 32'd3, B5);
        vt[22] = mk(3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0, 3'b000, Z_WE, Z_A, Z_D, B5);
        vt[23] = mk(3'b111, 6'd1, 6'd7, 6'd8, 32'd1, 32'd77, 32'd88, 1'b0, 6'd0, 3'b010, 1'b0, Z_A, Z_D, B5);

        rstn      = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        #2;
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_we",    64'(rf_we),     64'd0);
        check("reset_busy",  busy_vec,       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int k = 0; k < 24; k++) begin
            req_valid = vt[k].valid;
            req_addr  = vt[k].addr;
            req_data  = vt[k].data;
            rsv_valid = vt[k].rv;
            rsv_addr  = vt[k].ra;
            @(negedge clk);
            check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vt[k].erdy));
            check($sformatf("v%0d_we", k),    64'(rf_we),     64'(vt[k].ewe));
            check($sformatf("v%0d_waddr", k), 64'(rf_waddr),  64'(vt[k].ewa));
            check($sformatf("v%0d_wdata", k), 64'(rf_wdata),  64'(vt[k].ewd));
            check($sformatf("v%0d_busy", k),  busy_vec,       vt[k].ebusy);
            if (k == 10) check("rf_read_addr5", 64'(rfm[5]), 64'd200);
            @(posedge clk);
            #1;
        end

        // Requester 1 was granted on the last edge: reset lands while rf_we is high.
        check("pre_reset_we",   64'(rf_we),    64'd1);
        check("pre_reset_addr", 64'(rf_waddr), 64'd7);
        rstn = 1'b0;
        #1;
        check("midreset_we",    64'(rf_we),     64'd0);
        check("midreset_busy",  busy_vec,       64'd0);
        check("midreset_ready", 64'(req_ready), 64'd0);
        check("midreset_waddr", 64'(rf_waddr),  64'd0);
        check("midreset_wdata", 64'(rf_wdata),  64'd0);
        repeat (2) @(posedge clk);
        #1;

        rrd[0] = 32'd11;
        rrd[1] = 32'd22;
        rrd[2] = 32'd33;
        req_valid = 3'b111;
        req_addr  = {6'd3, 6'd2, 6'd1};
        req_data  = {rrd[2], rrd[1], rrd[0]};
        rsv_valid = 1'b0;
        rstn      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("rr%0d_ready", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
            if (i > 0) begin
                check($sformatf("rr%0d_we", i),    64'(rf_we),    64'd1);
                check($sformatf("rr%0d_wdata", i), 64'(rf_wdata), 64'(rrd[(i - 1) % 3]));
                check($sformatf("rr%0d_waddr", i), 64'(rf_waddr), 64'((i - 1) % 3 + 1));
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
